// File: rtl/calc_pkg.sv
// Shared definitions for the recombine datapath: default operand width,
// FSM state encoding and divide-by-zero status codes.
package calc_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] DZ_OK   = 2'b00;
  localparam logic [1:0] DZ_ZERO = 2'b01;

endpackage

// File: rtl/mod_recombine.sv
// Rebuilds a dividend as divisor*quotient + remainder with a serial shift-add multiplier.
// Optional remainder range flag enabled by defining MOD_RECOMBINE_RANGE_CHECK_EN.
module mod_recombine
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         divZero,
  output logic               range_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;
  logic [1:0]         r_dz;
  logic               w_capture;
  logic               w_done;

  assign w_capture = in_valid && in_ready;
  assign w_done    = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next = MUL;
      MUL:     if (w_done)    w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
  end

  // Capture stage: seed accumulator with the remainder, then one partial product per cycle.
  // The extra MUL cycle after the last step transfers the sum into the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_dz        <= DZ_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_acc    <= {{WIDTH{1'b0}}, remainder};
            r_mcand  <= {{WIDTH{1'b0}}, divisor};
            r_mplier <= quotient;
            r_cnt    <= '0;
            r_dz     <= (divisor == '0) ? DZ_ZERO : DZ_OK;
          end
        end
        MUL: begin
          if (!w_done) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end else begin
            r_result    <= r_acc;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign divZero   = r_dz;

`ifdef MOD_RECOMBINE_RANGE_CHECK_EN
  logic r_range_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_range_err <= 1'b0;
    else if (w_capture) r_range_err <= (divisor != '0) && (remainder >= divisor);
  end

  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_recombine.sv
// Scoreboard bench for mod_recombine: directed corner cases then randomized traffic.
module tb_mod_recombine;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic [1:0]     divZero;
  logic           range_err;

  mod_recombine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .divZero(divZero), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  dz;
    logic        re;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   active = 0;
  bit   hs_pending = 0;
  bit   rdy_rand = 0;
  logic [31:0] last_res;
  logic [1:0]  last_dz;
  logic        last_re;
  int          last_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic from the operand values on the ports.
  function automatic exp_t model(input logic [W-1:0] d, input logic [W-1:0] q, input logic [W-1:0] r);
    exp_t e;
    e.res = 32'(d) * 32'(q) + 32'(r);
    e.dz  = (d == 0) ? 2'b01 : 2'b00;
`ifdef MOD_RECOMBINE_RANGE_CHECK_EN
    e.re  = (d != 0) && (r >= d);
`else
    e.re  = 1'b0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  // Capture observer: pushes expectations when the DUT accepts operands.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && in_valid && in_ready) begin
      e = model(divisor, quotient, remainder);
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (!rst && out_valid && out_ready) hs_pending = 1;
  end

  // Monitor: pops on each new result, then checks it stays stable until the handshake.
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      hs_pending = 0;
    end else begin
      if (hs_pending) begin
        chk("hs_out_valid_low", out_valid, 0);
        chk("hs_in_ready_high", in_ready, 1);
        active = 0;
        hs_pending = 0;
      end
      if (out_valid && !active) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          cur = sb.pop_front();
          last_lat = cyc - cur.cyc;
          chk("latency", last_lat, W + 1);
          chk("result", result, cur.res);
          chk("divZero", divZero, cur.dz);
          chk("range_err", range_err, cur.re);
          last_res = result;
          last_dz = divZero;
          last_re = range_err;
        end
        active = 1;
      end else if (out_valid && active) begin
        chk("hold_result", result, cur.res);
        chk("hold_divZero", divZero, cur.dz);
        chk("hold_range_err", range_err, cur.re);
        chk("hold_in_ready", in_ready, 0);
      end else if (!out_valid && active) begin
        chk("out_valid_dropped", 1, 0);
        active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_op(input logic [W-1:0] d, input logic [W-1:0] q, input logic [W-1:0] r);
    int n = 0;
    divisor = d; quotient = q; remainder = r; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    divisor = W'($urandom); quotient = W'($urandom); remainder = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(sb.size() == 0 && !out_valid && in_ready) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] d, q, r;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    divisor = '0; quotient = '0; remainder = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_divZero", divZero, 0);
    chk("rst_range_err", range_err, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    out_ready = 1'b1;
    do_op(16'd7, 16'd5, 16'd3);
    wait_done();
    chk("d1_result", last_res, 38);
    chk("d1_divZero", last_dz, 0);
    chk("d1_latency", last_lat, 17);

    do_op(16'd65535, 16'd65535, 16'd65534);
    wait_done();
    chk("d2_result", last_res, 64'd4294901759);

    do_op(16'd0, 16'd1234, 16'd9);
    wait_done();
    chk("d3_result", last_res, 9);
    chk("d3_divZero", last_dz, 1);

    do_op(16'd5, 16'd2, 16'd5);
    wait_done();
    chk("d4_result", last_res, 15);
`ifdef MOD_RECOMBINE_RANGE_CHECK_EN
    chk("d4_range_err", last_re, 1);
`else
    chk("d4_range_err", last_re, 0);
`endif

    // Consumer stalls for ten cycles, then a single-cycle ready pulse.
    out_ready = 1'b0;
    do_op(16'd100, 16'd200, 16'd50);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("d5_out_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("d5_held_result", result, 20050);
      chk("d5_in_ready_low", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("d5_in_ready_after_pulse", in_ready, 1);
    chk("d5_out_valid_after_pulse", out_valid, 0);

    // Asynchronous reset in the middle of the multiply.
    out_ready = 1'b1;
    do_op(16'd1000, 16'd999, 16'd7);
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    chk("d6_rst_out_valid", out_valid, 0);
    chk("d6_rst_in_ready", in_ready, 1);
    chk("d6_rst_result", result, 0);
    chk("d6_rst_divZero", divZero, 0);
    chk("d6_rst_range_err", range_err, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    repeat (20) tick();
    chk("d6_no_stale_output", out_valid, 0);
    do_op(16'd3, 16'd4, 16'd1);
    wait_done();
    chk("d6_result", last_res, 13);

    // Randomized traffic with random consumer back-pressure.
    rdy_rand = 1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       d = '0;
        1:       d = 16'hFFFF;
        default: d = W'($urandom);
      endcase
      q = W'($urandom);
      r = ($urandom_range(0, 3) == 0) ? d : W'($urandom);
      do_op(d, q, r);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_done();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
